// File: rtl/snes_macro_player_if.sv
// Table programming bus for snes_macro_player.
// prog_we is a single-cycle write strobe with no back-pressure: every cycle with
// prog_we=1 is one write, and prog_err pulses the following cycle if it was refused.
interface snes_macro_player_if #(
   parameter int BITS      = 16,
   parameter int NUM_MOVES = 4,
   parameter int MAX_STEPS = 8
);
   localparam int MW = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1;
   localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

   logic          prog_we;
   logic [MW-1:0] prog_move;
   logic [SW-1:0] prog_step;
   logic [BITS-1:0] prog_data;
   logic          prog_last;
   logic          prog_err;

   modport master (output prog_we, prog_move, prog_step, prog_data, prog_last,
                   input  prog_err);
   modport slave  (input  prog_we, prog_move, prog_step, prog_data, prog_last,
                   output prog_err);
endinterface

// File: rtl/snes_macro_player.sv
// SNES controller macro player: passes the pad through, or replays a programmed move.
// Optional macro SNES_MACRO_MIRROR_EN swaps Left/Right of every word when dir=1 at trigger.
module snes_macro_player #(
   parameter int BITS        = 16,
   parameter int NUM_MOVES   = 4,
   parameter int MAX_STEPS   = 8,
   parameter int HOLD_FRAMES = 1
) (
   input  logic clk_system,
   input  logic reset,
   input  logic ctrl_clk,
   input  logic ctrl_latch,
   input  logic ctrl_in,
   output logic ctrl_out,
   input  logic [NUM_MOVES-1:0] move_select,
   input  logic dir,
   input  logic abort,
   snes_macro_player_if.slave prog,
   output logic busy,
   output logic done,
   output logic [((MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1)-1:0] step_idx,
   output logic [1:0] state_dbg
);
   localparam int MW = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1;
   localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
   localparam logic [3:0] HOLD = HOLD_FRAMES[3:0];

   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, PLAY = 2'd2, DONE = 2'd3} state_t;

   state_t          state;
   logic [2:0]      latch_sync, clk_sync;
   logic            latch_edge, clk_edge;
   logic [BITS-1:0] shreg;
   logic [3:0]      hold_cnt;
   logic [MW-1:0]   active;
   logic [BITS-1:0] words_q [NUM_MOVES][MAX_STEPS];
   logic [SW:0]     len [NUM_MOVES];
   logic            prog_err_q;
   logic            sel_hit;
   logic [MW-1:0]   sel_idx;
   logic [BITS-1:0] cur_word, next_word;
   logic            last_step;

`ifdef SNES_MACRO_MIRROR_EN
   logic mirror_q;
   function automatic logic [BITS-1:0] load_word(input logic [BITS-1:0] w);
      logic [BITS-1:0] r;
      r = w;
      if (mirror_q) begin
         r[9] = w[8];
         r[8] = w[9];
      end
      return r;
   endfunction
`else
   logic unused_dir;
   assign unused_dir = dir;
   function automatic logic [BITS-1:0] load_word(input logic [BITS-1:0] w);
      return w;
   endfunction
`endif

   assign latch_edge = latch_sync[1] & ~latch_sync[2];
   assign clk_edge   = clk_sync[1] & ~clk_sync[2];
   assign cur_word   = words_q[active][step_idx];
   assign next_word  = words_q[active][step_idx + SW'(1)];
   assign last_step  = ({1'b0, step_idx} == (len[active] - (SW+1)'(1)));
   assign busy       = (state != IDLE);
   assign state_dbg  = state;
   assign ctrl_out   = (state == PLAY || state == DONE) ? ~shreg[BITS-1] : ctrl_in;
   assign prog.prog_err = prog_err_q;

   // Lowest-index active-low select wins.
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      for (int i = NUM_MOVES - 1; i >= 0; i--) begin
         if (!move_select[i]) begin
            sel_hit = 1'b1;
            sel_idx = MW'(i);
         end
      end
   end

   // hold_cnt counts frames already presented for the current step (ARM load is frame 1).
   always_ff @(posedge clk_system) begin
      if (reset) begin
         state      <= IDLE;
         latch_sync <= '0;
         clk_sync   <= '0;
         shreg      <= '0;
         hold_cnt   <= '0;
         step_idx   <= '0;
         active     <= '0;
         done       <= 1'b0;
`ifdef SNES_MACRO_MIRROR_EN
         mirror_q   <= 1'b0;
`endif
      end else begin
         latch_sync <= {latch_sync[1:0], ctrl_latch};
         clk_sync   <= {clk_sync[1:0], ctrl_clk};
         done       <= 1'b0;
         if (abort) begin
            state    <= IDLE;
            step_idx <= '0;
            hold_cnt <= '0;
         end else begin
            case (state)
               IDLE: if (sel_hit) begin
                  active   <= sel_idx;
                  step_idx <= '0;
                  hold_cnt <= '0;
`ifdef SNES_MACRO_MIRROR_EN
                  mirror_q <= dir;
`endif
                  state    <= ARM;
               end
               ARM: if (latch_edge) begin
                  shreg    <= load_word(words_q[active][0]);
                  hold_cnt <= 4'd1;
                  state    <= PLAY;
               end
               PLAY: begin
                  if (latch_edge) begin
                     if (hold_cnt != HOLD) begin
                        shreg    <= load_word(cur_word);
                        hold_cnt <= hold_cnt + 4'd1;
                     end else if (last_step) begin
                        shreg    <= '0;
                        hold_cnt <= '0;
                        done     <= 1'b1;
                        state    <= DONE;
                     end else begin
                        step_idx <= step_idx + SW'(1);
                        shreg    <= load_word(next_word);
                        hold_cnt <= 4'd1;
                     end
                  end else if (clk_edge) begin
                     shreg <= {shreg[BITS-2:0], 1'b0};
                  end
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Writes to the move being played are refused so playback never sees a torn table.
   always_ff @(posedge clk_system) begin
      if (reset) begin
         for (int m = 0; m < NUM_MOVES; m++) begin
            len[m] <= (SW+1)'(1);
            for (int s = 0; s < MAX_STEPS; s++) words_q[m][s] <= '0;
         end
         prog_err_q <= 1'b0;
      end else begin
         prog_err_q <= 1'b0;
         if (prog.prog_we) begin
            if (busy && prog.prog_move == active) begin
               prog_err_q <= 1'b1;
            end else begin
               words_q[prog.prog_move][prog.prog_step] <= prog.prog_data;
               if (prog.prog_last)
                  len[prog.prog_move] <= {1'b0, prog.prog_step} + (SW+1)'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_snes_macro_player.sv
// Bench for snes_macro_player: two instances (HOLD_FRAMES 1 and 3) on a shared pad bus,
// frames captured by a monitor and compared against an expected-word scoreboard.
module tb_snes_macro_player;
   logic clk_system = 1'b0;
   logic reset, ctrl_clk, ctrl_latch, ctrl_in, abort, dir;
   logic [3:0] sel_a, sel_b;
   logic ctrl_out_a, ctrl_out_b, busy_a, busy_b, done_a, done_b;
   logic [2:0] step_a, step_b;
   logic [1:0] st_a, st_b;
   logic p_we_a, p_we_b, p_last;
   logic [1:0] p_move;
   logic [2:0] p_step;
   logic [15:0] p_data;

   logic [15:0] exp_qa[$];
   logic [15:0] exp_qb[$];
   int checks = 0;
   int errors = 0;
   int done_cnt_a = 0, done_cnt_b = 0, err_cnt_a = 0;
   logic [15:0] m1, m2, m3;

   // clock / reset
   always #5 clk_system = ~clk_system;

   snes_macro_player_if if_a ();
   snes_macro_player_if if_b ();

   assign if_a.prog_we   = p_we_a;
   assign if_a.prog_move = p_move;
   assign if_a.prog_step = p_step;
   assign if_a.prog_data = p_data;
   assign if_a.prog_last = p_last;
   assign if_b.prog_we   = p_we_b;
   assign if_b.prog_move = p_move;
   assign if_b.prog_step = p_step;
   assign if_b.prog_data = p_data;
   assign if_b.prog_last = p_last;

   snes_macro_player #(.HOLD_FRAMES(1)) dut_a (
      .clk_system(clk_system), .reset(reset), .ctrl_clk(ctrl_clk), .ctrl_latch(ctrl_latch),
      .ctrl_in(ctrl_in), .ctrl_out(ctrl_out_a), .move_select(sel_a), .dir(dir), .abort(abort),
      .prog(if_a), .busy(busy_a), .done(done_a), .step_idx(step_a), .state_dbg(st_a));

   snes_macro_player #(.HOLD_FRAMES(3)) dut_b (
      .clk_system(clk_system), .reset(reset), .ctrl_clk(ctrl_clk), .ctrl_latch(ctrl_latch),
      .ctrl_in(ctrl_in), .ctrl_out(ctrl_out_b), .move_select(sel_b), .dir(dir), .abort(abort),
      .prog(if_b), .busy(busy_b), .done(done_b), .step_idx(step_b), .state_dbg(st_b));

   always @(negedge clk_system) begin
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      if (if_a.prog_err) err_cnt_a++;
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk_system);
   endtask

   task automatic push2(input logic [15:0] ea, input logic [15:0] eb);
      exp_qa.push_back(ea);
      exp_qb.push_back(eb);
   endtask

   // driver tasks
   task automatic prog_w(input bit to_b, input logic [1:0] mv, input logic [2:0] st,
                         input logic [15:0] data, input logic last);
      p_move = mv; p_step = st; p_data = data; p_last = last;
      if (to_b) p_we_b = 1'b1; else p_we_a = 1'b1;
      nclk(1);
      p_we_a = 1'b0; p_we_b = 1'b0;
      nclk(2);
   endtask

   // mode 0: plain frame; 1: abort after clock pulse 'at'; 2: reset after clock pulse 'at'
   task automatic send_frame(input int mode, input int at);
      ctrl_latch = 1'b1; nclk(6);
      ctrl_latch = 1'b0; nclk(6);
      for (int i = 0; i < 16; i++) begin
         ctrl_clk = 1'b1; nclk(6);
         ctrl_clk = 1'b0; nclk(2);
         if (mode != 0 && i == at) begin
            ctrl_in = 1'b0;
            if (mode == 1) abort = 1'b1; else reset = 1'b1;
            nclk(1);
            abort = 1'b0; reset = 1'b0;
            check(mode == 1 ? "abort_passthrough" : "reset_passthrough", ctrl_out_a, 16'h0);
            check(mode == 1 ? "abort_busy" : "reset_busy", busy_a, 16'h0);
            ctrl_in = 1'b1;
         end
         nclk(4);
      end
      nclk(4);
   endtask

   task automatic send_frames(input int n);
      for (int k = 0; k < n; k++) send_frame(0, 0);
   endtask

   // scoreboard monitor: assemble each serial frame MSB first and pop the expectation
   initial begin : monitor
      logic [15:0] wa, wb;
      forever begin
         @(negedge ctrl_latch);
         wa[15] = ctrl_out_a; wb[15] = ctrl_out_b;
         for (int b = 14; b >= 0; b--) begin
            @(negedge ctrl_clk);
            wa[b] = ctrl_out_a; wb[b] = ctrl_out_b;
         end
         if (exp_qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_a: unexpected frame got %h", wa);
         end else check("frame_a", wa, exp_qa.pop_front());
         if (exp_qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_b: unexpected frame got %h", wb);
         end else check("frame_b", wb, exp_qb.pop_front());
      end
   end

   initial begin : watchdog
      repeat (60000) @(posedge clk_system);
      checks++; errors++;
      $display("FAIL watchdog: bench did not complete within cycle budget");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : stimulus
      int d0, e0;
      reset = 1'b1; ctrl_clk = 1'b0; ctrl_latch = 1'b0; ctrl_in = 1'b1;
      abort = 1'b0; dir = 1'b0; sel_a = 4'hF; sel_b = 4'hF;
      p_we_a = 1'b0; p_we_b = 1'b0; p_last = 1'b0; p_move = '0; p_step = '0; p_data = '0;
`ifdef SNES_MACRO_MIRROR_EN
      m1 = 16'hF9FF; m2 = 16'hFDFF; m3 = 16'hBDFF;
`else
      m1 = 16'hFAFF; m2 = 16'hFEFF; m3 = 16'hBEFF;
`endif
      nclk(4);
      reset = 1'b0;
      nclk(1);

      // reset state
      check("reset_busy_a", busy_a, 16'h0);
      check("reset_busy_b", busy_b, 16'h0);
      check("reset_done", done_a, 16'h0);
      check("reset_prog_err", if_a.prog_err, 16'h0);
      check("reset_step_idx", step_a, 16'h0);
      ctrl_in = 1'b0; #1;
      check("reset_pass_lo", ctrl_out_a, 16'h0);
      ctrl_in = 1'b1; #1;
      check("reset_pass_hi", ctrl_out_b, 16'h1);

      // tables
      prog_w(0, 2'd0, 3'd0, 16'h0400, 1'b0);
      prog_w(0, 2'd0, 3'd1, 16'h0500, 1'b0);
      prog_w(0, 2'd0, 3'd2, 16'h0100, 1'b0);
      prog_w(0, 2'd0, 3'd3, 16'h4100, 1'b1);
      prog_w(0, 2'd1, 3'd0, 16'h0080, 1'b0);
      prog_w(0, 2'd1, 3'd1, 16'h8080, 1'b1);
      prog_w(1, 2'd0, 3'd0, 16'h8000, 1'b0);
      prog_w(1, 2'd0, 3'd1, 16'h0080, 1'b1);
      check("idle_write_no_err", err_cnt_a, 16'h0);

      // basic 4-step move, HOLD_FRAMES=1
      d0 = done_cnt_a;
      sel_a = 4'b1110; nclk(3); sel_a = 4'hF;
      check("arm_busy", busy_a, 16'h1);
      push2(16'hFBFF, 16'hFFFF); push2(16'hFAFF, 16'hFFFF);
      push2(16'hFEFF, 16'hFFFF); push2(16'hBEFF, 16'hFFFF);
      push2(16'hFFFF, 16'hFFFF);
      send_frames(5);
      check("move0_busy_after", busy_a, 16'h0);
      check("move0_done_pulses", 16'(done_cnt_a - d0), 16'h1);

      // dir=1: mirrored only when the mirror feature is built in
      dir = 1'b1;
      sel_a = 4'b1110; nclk(3); sel_a = 4'hF;
      dir = 1'b0;
      push2(16'hFBFF, 16'hFFFF); push2(m1, 16'hFFFF);
      push2(m2, 16'hFFFF); push2(m3, 16'hFFFF);
      push2(16'hFFFF, 16'hFFFF);
      send_frames(5);

      // HOLD_FRAMES=3, 2-step move on the second instance
      d0 = done_cnt_b;
      sel_b = 4'b1110; nclk(3); sel_b = 4'hF;
      check("hold3_busy", busy_b, 16'h1);
      for (int k = 0; k < 3; k++) push2(16'hFFFF, 16'h7FFF);
      for (int k = 0; k < 3; k++) push2(16'hFFFF, 16'hFF7F);
      push2(16'hFFFF, 16'hFFFF);
      send_frames(7);
      check("hold3_busy_after", busy_b, 16'h0);
      check("hold3_done_pulses", 16'(done_cnt_b - d0), 16'h1);

      // abort during the step-2 frame
      d0 = done_cnt_a;
      sel_a = 4'b1110; nclk(3); sel_a = 4'hF;
      push2(16'hFBFF, 16'hFFFF); push2(16'hFAFF, 16'hFFFF);
      send_frames(2);
      push2(16'hFFFF, 16'hFFFF);
      send_frame(1, 2);
      push2(16'hFFFF, 16'hFFFF);
      send_frames(1);
      check("abort_no_done", 16'(done_cnt_a - d0), 16'h0);
      check("abort_idle", busy_a, 16'h0);

      // writes while playing move1
      d0 = done_cnt_a;
      e0 = err_cnt_a;
      sel_a = 4'b1101; nclk(3); sel_a = 4'hF;
      prog_w(0, 2'd1, 3'd0, 16'hFFFF, 1'b0);
      check("active_write_err", 16'(err_cnt_a - e0), 16'h1);
      prog_w(0, 2'd2, 3'd0, 16'h0040, 1'b1);
      check("other_write_ok", 16'(err_cnt_a - e0), 16'h1);
      push2(16'hFF7F, 16'hFFFF); push2(16'h7F7F, 16'hFFFF); push2(16'hFFFF, 16'hFFFF);
      send_frames(3);
      sel_a = 4'b1011; nclk(3); sel_a = 4'hF;
      push2(16'hFFBF, 16'hFFFF); push2(16'hFFFF, 16'hFFFF);
      send_frames(2);
      check("move1_move2_done", 16'(done_cnt_a - d0), 16'h2);

      // lowest-index select, later select changes ignored
      d0 = done_cnt_a;
      sel_a = 4'b1100; nclk(3);
      push2(16'hFBFF, 16'hFFFF);
      send_frames(1);
      sel_a = 4'b0100;
      push2(16'hFAFF, 16'hFFFF); push2(16'hFEFF, 16'hFFFF); push2(16'hBEFF, 16'hFFFF);
      send_frames(3);
      sel_a = 4'hF;
      push2(16'hFFFF, 16'hFFFF);
      send_frames(1);
      check("select_done", 16'(done_cnt_a - d0), 16'h1);
      check("select_busy_after", busy_a, 16'h0);

      // reset mid-frame
      d0 = done_cnt_a;
      sel_a = 4'b1110; nclk(3); sel_a = 4'hF;
      push2(16'hFFFF, 16'hFFFF);
      send_frame(2, 2);
      check("reset_mid_no_done", 16'(done_cnt_a - d0), 16'h0);

      nclk(10);
      check("queue_a_drained", 16'(exp_qa.size()), 16'h0);
      check("queue_b_drained", 16'(exp_qb.size()), 16'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/snes_macro_player.md
SNES_MACRO_PLAYER -- requirements
Module: snes_macro_player

Interface
REQ-001 SHALL have parameter BITS, default 16: controller serial frame width, MSB shifted first (bit15=B, 14=Y, 10=Down, 9=Left, 8=Right, 7=A).
REQ-002 SHALL have parameter NUM_MOVES, default 4: number of programmable move sequences.
REQ-003 SHALL have parameter MAX_STEPS, default 8: maximum steps per move.
REQ-004 SHALL have parameter HOLD_FRAMES, default 1, legal range 1..15: frames each step is held.
REQ-005 SHALL have port clk_system, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports ctrl_clk and ctrl_latch, each input, 1: console controller clock and latch, asynchronous to clk_system.
REQ-008 SHALL have port ctrl_in, input, 1: serial data from the physical pad.
REQ-009 SHALL have port ctrl_out, output, 1: serial data to the console.
REQ-010 SHALL have port move_select, input, NUM_MOVES: active-low trigger, one bit per move.
REQ-011 SHALL have ports dir (input, 1: 0=facing right, 1=facing left) and abort (input, 1: cancel playback).
REQ-012 SHALL have ports prog_we (1), prog_move (clog2 NUM_MOVES), prog_step (clog2 MAX_STEPS), prog_data (BITS, 1=pressed) and prog_last (1), all inputs: table write port.
REQ-013 SHALL have outputs busy (1), done (1-cycle pulse), prog_err (1-cycle pulse) and step_idx (clog2 MAX_STEPS).

Function
REQ-014 SHALL pass ctrl_latch and ctrl_clk each through a 2-flop synchronizer and detect rising edges; clk_system is at least 8x ctrl_clk.
REQ-015 SHALL implement the states IDLE, ARM, PLAY and DONE.
REQ-016 In IDLE, SHALL capture the lowest-index low bit of move_select as the active move and go to ARM; move_select SHALL be ignored in any other state.
REQ-017 In ARM, SHALL go to PLAY on the next latch edge and load the step-0 word.
REQ-018 On each latch edge in PLAY, SHALL load the shift register with the current step word and increment the hold counter.
REQ-019 When the hold counter reaches HOLD_FRAMES, SHALL advance step_idx and clear the hold counter.
REQ-020 After the frame for the last step (index len[move]-1) has been held HOLD_FRAMES frames, the next latch edge SHALL enter DONE, which loads an all-released word.
REQ-021 DONE SHALL pulse done for one cycle and return to IDLE on the following cycle.
REQ-022 On each synchronized ctrl_clk rising edge while overriding, SHALL shift left, filling with 0 (released).
REQ-023 ctrl_out SHALL equal ~shreg[BITS-1] in PLAY and DONE, and SHALL equal ctrl_in combinationally in IDLE and ARM.
REQ-024 busy SHALL be high in ARM, PLAY and DONE.
REQ-025 abort SHALL force IDLE on the next edge from any state; passthrough resumes that cycle, with no done pulse.
REQ-026 SHALL hold a table of NUM_MOVES x MAX_STEPS words plus a per-move length len in 1..MAX_STEPS.
REQ-027 A prog_we write SHALL store prog_data; if prog_last is also high, it SHALL set len[prog_move] = prog_step+1.
REQ-028 While busy, a write with prog_move equal to the active move SHALL be dropped and SHALL pulse prog_err.
REQ-029 When a latch edge and a ctrl_clk edge are detected in the same cycle, the latch load SHALL take priority over the shift.

Reset
REQ-030 On reset=1 at a clock edge, SHALL set state=IDLE, shreg=0, step_idx=0, hold counter=0, every table word=0 and every len=1.
REQ-031 On reset, SHALL drive busy=0, done=0 and prog_err=0; ctrl_out SHALL follow ctrl_in.
REQ-032 Reset asserted mid-frame SHALL immediately restore passthrough.

Configuration
REQ-033 SHALL support macro SNES_MACRO_MIRROR_EN.
REQ-034 When SNES_MACRO_MIRROR_EN is defined, if dir=1 at the IDLE->ARM transition, every loaded word SHALL have bits 9 (Left) and 8 (Right) swapped; dir is latched once per move.
REQ-035 When SNES_MACRO_MIRROR_EN is undefined, dir SHALL be ignored and words SHALL be loaded unmodified.

Verification
REQ-036 Program move0 as steps {0x0400, 0x0500, 0x0100, 0x4100} with len=4 and HOLD_FRAMES=1, pull move_select low -> over 4 latch frames ctrl_out streams ~word (e.g. 16'hFBFF first), then an all-1s frame, a done pulse and busy=0.
REQ-037 With MIRROR_EN defined, dir=1 and the same move -> the step-1 frame reads 16'hF9FF with Left low instead of Right.
REQ-038 With HOLD_FRAMES=3 and a 2-step move -> each word repeats for 3 frames, giving 6 override frames, then the release frame.
REQ-039 Assert abort during the step-2 frame -> ctrl_out equals ctrl_in in the next cycle, busy=0 and no done pulse.
REQ-040 While playing move1, write to move1 -> prog_err pulses and the table is unchanged; a write to move2 succeeds.
REQ-041 Drive move_select=4'b1100 -> move 0 plays; pulling bit 3 low mid-play has no effect.
